// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the divider scheduler and its iterative core.
package div_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider, one quotient bit per step; start loads operands, done flags the final step.
// Results are combinational from the working registers; a zero divisor reports all-ones / dividend.
module div_core
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // rem_sh carries the bit shifted out of rem so the compare never overflows.
  always_comb begin
    rem_d   = rem_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rem_sh  = {rem_q, shreg_q[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - divisor_i;
    if (start_i) begin
      rem_d   = '0;
      shreg_d = dividend_i;
      cnt_d   = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (rem_sh >= {1'b0, divisor_i}) begin
        rem_d   = rem_sub;
        shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d   = rem_sh[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done_o      = step_i && (cnt_q == CW'(WIDTH - 1));
  assign quotient_o  = (divisor_i == '0) ? '1 : shreg_q;
  assign remainder_o = (divisor_i == '0) ? shreg_q : rem_q;

endmodule

// File: rtl/div_scheduler.sv
// Arbitrates N_REQ requesters onto one iterative divider; ack-to-rsp_valid is WIDTH+2 cycles (2 for divide by zero).
// Requests are level-held until ack; DIV_SCHED_ROUND_ROBIN_EN selects round-robin, otherwise lowest index wins.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   dividend,
  input  logic [N_REQ*WIDTH-1:0]   divisor,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         quotient,
  output logic [WIDTH-1:0]         remainder,
  output logic                     div_zero
);
  localparam int IDW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic             win_vld, take;
  logic [IDW-1:0]   win_idx, id_q, id_hold_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, quot_hold_q, rem_hold_q;
  logic [WIDTH-1:0] core_quot, core_rem;
  logic             core_done;

`ifdef DIV_SCHED_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;

  // First pass searches from the pointer upward, second pass wraps to the low indices.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i] && (IDW'(i) >= ptr_q)) begin
        win_vld = 1'b1;
        win_idx = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win_idx = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win_idx = IDW'(i);
      end
    end
  end
`endif

  assign take = !rst && (state_q == IDLE) && win_vld;
  assign ack  = take ? (N_REQ'(1) << win_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      id_q  <= '0;
    end else if (take) begin
      dvd_q <= dividend[int'(win_idx)*WIDTH +: WIDTH];
      dvs_q <= divisor[int'(win_idx)*WIDTH +: WIDTH];
      id_q  <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero divisor skips RUN; the core already presents all-ones / dividend.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = LOAD;
      LOAD:    state_d = (dvs_q == '0) ? DONE : RUN;
      RUN:     if (core_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (state_q == LOAD),
    .step_i      (state_q == RUN),
    .dividend_i  (dvd_q),
    .divisor_i   (dvs_q),
    .done_o      (core_done),
    .quotient_o  (core_quot),
    .remainder_o (core_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_hold_q <= '0;
      rem_hold_q  <= '0;
      id_hold_q   <= '0;
    end else if (rsp_valid) begin
      quot_hold_q <= core_quot;
      rem_hold_q  <= core_rem;
      id_hold_q   <= id_q;
    end
  end

  assign busy      = !rst && (state_q != IDLE);
  assign rsp_valid = !rst && (state_q == DONE);
  assign div_zero  = rsp_valid && (dvs_q == '0);
  assign quotient  = rst ? '0 : (rsp_valid ? core_quot : quot_hold_q);
  assign remainder = rst ? '0 : (rsp_valid ? core_rem : rem_hold_q);
  assign rsp_id    = rst ? '0 : (rsp_valid ? id_q : id_hold_q);

endmodule
